operand_stack: RTL
==================

# operand_stack

Operand stack for the 16-bit stack CPU, sitting directly upstream of the ALU. Holds up to DEPTH 16-bit words and presents top-of-stack (TOS) and next-on-stack (NOS) to the ALU operand ports. Executes one stack command per accepted handshake and writes the ALU result back. Latches the ALU's four status flags on every ALU command.

## Interface
- DEPTH, 16: stack capacity in words, power of two, at least 4.
- PW, 5: pointer width, equal to log2(DEPTH)+1.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept; equals 1 in RUN, 0 in FAULT.
- cmd  in  3  command code: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 ALU1, 6 ALU2, 7 reserved (illegal).
- din  in  16  PUSH data.
- alop_in  in  3  ALU operation for ALU1/ALU2; forwarded unchanged.
- alu_x  out  16  NOS during ALU2, otherwise TOS.
- alu_y  out  16  TOS.
- alop  out  3  copy of alop_in.
- alu_z  in  16  ALU result, same cycle.
- alu_flags  in  4  ALU flags: bit0 SF, bit1 CF, bit2 ZF, bit3 OF.
- tos  out  16  current TOS; 0 when empty.
- depth  out  PW  number of valid entries.
- flags  out  4  latched flags.
- fault  out  1  high in FAULT state.
- err  out  2  fault cause: 0 none, 1 underflow, 2 overflow, 3 illegal command.
- fault_clr  in  1  single-cycle pulse; returns FAULT to RUN.

## Operation
- Storage: register array mem[0..DEPTH-1] and stack pointer sp (0..DEPTH). TOS is mem[sp-1]; NOS is mem[sp-2]. A missing entry reads as 0.
- Accept: cmd_valid && cmd_ready at a clock edge. Exactly one command executes per accept.
- NOP: no change.
- PUSH: mem[sp] <= din; sp+1. Requires sp < DEPTH.
- POP: sp-1. Requires sp >= 1.
- DUP: mem[sp] <= TOS; sp+1. Requires 1 <= sp < DEPTH.
- SWAP: exchange TOS and NOS. Requires sp >= 2.
- ALU1: mem[sp-1] <= alu_z; flags <= alu_flags. Requires sp >= 1.
- ALU2: mem[sp-2] <= alu_z; sp-1; flags <= alu_flags. Requires sp >= 2.
- A requirement violation or cmd 7 is treated as a fault:
  - stack, sp and flags are left unchanged;
  - the state moves to FAULT and err is set to the cause.
- Flags change only on successful ALU1/ALU2.
- State machine has two states:
  - RUN to FAULT on a faulting accept.
  - FAULT to RUN on fault_clr; err is cleared at the same time.
  - fault_clr in RUN has no effect.
- Reset values: sp=0, flags=0, state RUN, err=0. Consequently tos=0, depth=0, cmd_ready=1, fault=0. The mem contents need no reset.
- The pointer never wraps; overflow and underflow are always caught as faults.

## Timing
- alu_x, alu_y and alop are combinational from sp, mem, cmd and alop_in. The ALU result is consumed in the same cycle, with zero added latency.
- The result of an accepted command is visible on tos, depth and flags the cycle after the edge.
- Back-to-back accepts every cycle are supported. Each command sees the state left by the previous command.
- fault and err rise the cycle after the faulting edge. cmd_ready is 0 from that cycle on.
- If fault_clr and cmd_valid are both high while in FAULT, the command is not accepted. cmd_ready rises the following cycle.
- Reset asserted mid-stream discards any in-flight command. Outputs reach their reset values immediately and asynchronously.

## Test plan
- Reset, then PUSH 0x0003 and PUSH 0x0005, then ALU2 with alop_in=1 and alu_z driven as alu_x+alu_y. Expect alu_x=0x0003 and alu_y=0x0005 during the ALU2 cycle. Afterwards tos=0x0008, depth=1, flags=0000.
- PUSH 0x7FFF, then ALU1 with alu_z=0x8000 and alu_flags=1001. Expect tos=0x8000 and flags=1001. A following PUSH leaves flags=1001.
- PUSH 0x1111, PUSH 0x2222, SWAP, POP. Expect tos=0x2222 and depth=1.
- POP on an empty stack. Expect fault=1, err=1, cmd_ready=0, depth=0. Then pulse fault_clr: expect fault=0, err=0, cmd_ready=1.
- Perform DEPTH PUSHes, then one more PUSH. Expect err=2 and depth=DEPTH, with TOS unchanged. Separately, cmd=7 in RUN gives err=3.
- Assert rst mid-sequence with depth=3 and flags nonzero. Expect depth=0, tos=0, flags=0 and fault=0 asynchronously.

Source files
------------

// File: rtl/operand_stack.sv
// operand_stack: DEPTH-word operand stack feeding TOS/NOS to the ALU, with result write-back,
// latched ALU flags and a RUN/FAULT state machine that traps underflow, overflow and illegal commands.
module operand_stack #(
  parameter int DEPTH = 16,
  parameter int PW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd,
  input  logic [15:0]   din,
  input  logic [2:0]    alop_in,
  output logic [15:0]   alu_x,
  output logic [15:0]   alu_y,
  output logic [2:0]    alop,
  input  logic [15:0]   alu_z,
  input  logic [3:0]    alu_flags,
  output logic [15:0]   tos,
  output logic [PW-1:0] depth,
  output logic [3:0]    flags,
  output logic          fault,
  output logic [1:0]    err,
  input  logic          fault_clr
);
  localparam int AW = PW - 1;
  localparam logic [2:0] C_PUSH = 3'd1, C_POP = 3'd2, C_DUP = 3'd3, C_SWAP = 3'd4,
                         C_ALU1 = 3'd5, C_ALU2 = 3'd6, C_ILL = 3'd7;

  typedef enum logic {RUN, FAULT} state_t;

  state_t        r_state;
  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_sp;
  logic [3:0]    r_flags;
  logic [1:0]    r_err;

  logic [AW-1:0] w_i0, w_i1, w_i2;
  logic [15:0]   w_tos, w_nos;
  logic [1:0]    w_err;
  logic          w_acc, w_ok, w_full;
  logic [PW-1:0] w_sp_next;

  assign w_i0   = r_sp[AW-1:0];
  assign w_i1   = AW'(r_sp - PW'(1));
  assign w_i2   = AW'(r_sp - PW'(2));
  assign w_tos  = (r_sp >= PW'(1)) ? r_mem[w_i1] : 16'h0;
  assign w_nos  = (r_sp >= PW'(2)) ? r_mem[w_i2] : 16'h0;
  assign w_full = (r_sp == PW'(DEPTH));

  // Fault cause of the presented command against the current pointer; 0 means it may execute.
  assign w_err = (cmd == C_ILL) ? 2'd3 :
                 ((cmd == C_POP || cmd == C_DUP || cmd == C_ALU1) && r_sp == '0) ? 2'd1 :
                 ((cmd == C_SWAP || cmd == C_ALU2) && r_sp < PW'(2)) ? 2'd1 :
                 ((cmd == C_PUSH || cmd == C_DUP) && w_full) ? 2'd2 : 2'd0;

  assign w_acc = cmd_valid && (r_state == RUN);
  assign w_ok  = w_acc && (w_err == 2'd0);

  assign w_sp_next = (cmd == C_PUSH || cmd == C_DUP) ? r_sp + PW'(1) :
                     (cmd == C_POP || cmd == C_ALU2) ? r_sp - PW'(1) : r_sp;

  assign alu_x     = (cmd == C_ALU2) ? w_nos : w_tos;
  assign alu_y     = w_tos;
  assign alop      = alop_in;
  assign tos       = w_tos;
  assign depth     = r_sp;
  assign flags     = r_flags;
  assign err       = r_err;
  assign fault     = (r_state == FAULT);
  assign cmd_ready = (r_state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_sp    <= '0;
      r_flags <= 4'h0;
      r_err   <= 2'd0;
    end else if (r_state == RUN) begin
      if (w_acc && w_err != 2'd0) begin
        r_state <= FAULT;
        r_err   <= w_err;
      end else if (w_ok) begin
        r_sp <= w_sp_next;
        if (cmd == C_ALU1 || cmd == C_ALU2) r_flags <= alu_flags;
      end
    end else if (fault_clr) begin
      r_state <= RUN;
      r_err   <= 2'd0;
    end
  end

  // Storage carries no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (w_ok && !rst) begin
      if (cmd == C_PUSH) r_mem[w_i0] <= din;
      if (cmd == C_DUP)  r_mem[w_i0] <= w_tos;
      if (cmd == C_SWAP) begin
        r_mem[w_i1] <= w_nos;
        r_mem[w_i2] <= w_tos;
      end
      if (cmd == C_ALU1) r_mem[w_i1] <= alu_z;
      if (cmd == C_ALU2) r_mem[w_i2] <= alu_z;
    end
  end
endmodule
